tohost_monitor: RTL

TOHOST_MONITOR -- requirements
Module: tohost_monitor

---
 rtl/tohost_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tohost_monitor
// Purpose  : Passive AXI4-Lite write snooper that turns a tohost mailbox
//            write (or a timeout / channel overflow) into a test verdict.
// Revision : 1.0  initial release
// ============================================================================
module tohost_monitor #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR  = 'h00006000,
    parameter logic [DATA_WIDTH-1:0] SUCCESS_CODE = 1,
    parameter int                    MAX_CYCLES   = 100000,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    aw_valid,
    input  logic                    aw_ready,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic                    w_valid,
    input  logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic                    proto_err,
    output logic [DATA_WIDTH-1:0]   code,
    output logic [DATA_WIDTH-2:0]   test_num,
    output logic [CNT_WIDTH-1:0]    cycles
);

    localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_PASS    = 2'd1,
        S_FAIL    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t                  state;
    logic                    aw_slot_full;
    logic                    aw_slot_hit;
    logic                    w_slot_full;
    logic                    w_slot_strb_full;
    logic [DATA_WIDTH-1:0]   w_slot_data;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    eval_now;
    logic                    eval_hit;
    logic                    eval_strb_full;
    logic [DATA_WIDTH-1:0]   eval_data;
    logic                    eval_ok;
    logic                    overflow;
    logic                    at_limit;

    assign aw_hs    = aw_valid & aw_ready;
    assign w_hs     = w_valid & w_ready;
    assign eval_now = (aw_slot_full | aw_hs) & (w_slot_full | w_hs);

    // The oldest beat of each channel is the one paired up, so slots win.
    assign eval_hit       = aw_slot_full ? aw_slot_hit : (aw_addr == TOHOST_ADDR);
    assign eval_strb_full = w_slot_full ? w_slot_strb_full : (&w_strb);
    assign eval_data      = w_slot_full ? w_slot_data : w_data;
    assign eval_ok        = eval_strb_full & (eval_data == SUCCESS_CODE);

    assign overflow = (aw_hs & aw_slot_full) | (w_hs & w_slot_full);
    // Inclusive compare so a non-hit write on the last cycle cannot skip the deadline.
    assign at_limit = (cycles >= LAST_CYCLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_RUN;
            aw_slot_full     <= 1'b0;
            aw_slot_hit      <= 1'b0;
            w_slot_full      <= 1'b0;
            w_slot_strb_full <= 1'b0;
            w_slot_data      <= '0;
            cycles           <= '0;
            code             <= '0;
            test_num         <= '0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail             <= 1'b0;
            timeout          <= 1'b0;
            proto_err        <= 1'b0;
        end else if (state == S_RUN) begin
            // A handshake arriving while its slot is consumed refills the slot.
            if (eval_now) begin
                aw_slot_full <= aw_slot_full & aw_hs;
                w_slot_full  <= w_slot_full & w_hs;
            end else begin
                if (aw_hs) aw_slot_full <= 1'b1;
                if (w_hs)  w_slot_full  <= 1'b1;
            end
            if (aw_hs) aw_slot_hit <= (aw_addr == TOHOST_ADDR);
            if (w_hs) begin
                w_slot_data      <= w_data;
                w_slot_strb_full <= &w_strb;
            end

            if (eval_now && eval_hit) begin
                state    <= eval_ok ? S_PASS : S_FAIL;
                pass     <= eval_ok;
                fail     <= ~eval_ok;
                done     <= 1'b1;
                code     <= eval_data;
                test_num <= eval_data[DATA_WIDTH-1:1];
            end else if (!eval_now && overflow) begin
                state     <= S_FAIL;
                fail      <= 1'b1;
                proto_err <= 1'b1;
                done      <= 1'b1;
                code      <= '0;
                test_num  <= '0;
            end else if (!eval_now && at_limit) begin
                state    <= S_TIMEOUT;
                timeout  <= 1'b1;
                done     <= 1'b1;
                code     <= '0;
                test_num <= '0;
            end else if (cycles != {CNT_WIDTH{1'b1}}) begin
                cycles <= cycles + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
